// File: rtl/store_queue_unit_pkg.sv
// Shared definitions for the store queue: pop FSM states and width helpers.
package store_queue_unit_pkg;

  // Pop FSM: ISSUE sends the low beat of the head entry, SPLIT the high beat.
  typedef enum logic {
    S_ISSUE = 1'b0,
    S_SPLIT = 1'b1
  } sq_state_e;

  // Number of byte lanes in an SRAM word.
  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Width of the in-word byte offset.
  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/store_queue_unit_if.sv
// Store request and data-SRAM write port bundle.
interface store_queue_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int BYTES = store_queue_unit_pkg::bytes_of(DATA_W);
  localparam int OFF_W = store_queue_unit_pkg::off_w_of(DATA_W);

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata;
  logic [OFF_W:0]    st_mode;
  logic              store_err;
  logic              sq_empty;
  logic              data_sram_req;
  logic              data_sram_addr_ok;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [BYTES-1:0]  data_sram_we;
  logic [DATA_W-1:0] data_sram_wdata;

  // Producer side (pipeline stage / testbench), also owns the SRAM acceptance.
  modport master (
    output st_valid, st_addr, st_wdata, st_mode, data_sram_addr_ok,
    input  st_ready, store_err, sq_empty,
    input  data_sram_req, data_sram_addr, data_sram_we, data_sram_wdata
  );

  // Store queue side.
  modport slave (
    input  st_valid, st_addr, st_wdata, st_mode, data_sram_addr_ok,
    output st_ready, store_err, sq_empty,
    output data_sram_req, data_sram_addr, data_sram_we, data_sram_wdata
  );
endinterface

// File: rtl/store_queue_unit_align.sv
// Combinational store decode: lane-shifts data and strobes over two words.
module store_queue_unit_align
  import store_queue_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [off_w_of(DATA_W)-1:0] i_off,
  input  logic [off_w_of(DATA_W):0]   i_mode,
  input  logic [DATA_W-1:0]           i_data,
  output logic [DATA_W-1:0]           o_lo,
  output logic [DATA_W-1:0]           o_hi,
  output logic [bytes_of(DATA_W)-1:0] o_strb_lo,
  output logic [bytes_of(DATA_W)-1:0] o_strb_hi,
  output logic                        o_split,
  output logic                        o_illegal
);
  localparam int BYTES = bytes_of(DATA_W);
  localparam int OFF_W = off_w_of(DATA_W);

  logic [2*BYTES-1:0]  w_size_mask_per [OFF_W+1];
  logic [2*BYTES-1:0]  w_size_mask;
  logic [2*BYTES-1:0]  w_strb;
  logic [2*DATA_W-1:0] w_lane_mask;
  logic [2*DATA_W-1:0] w_shifted;

  // One right-justified byte mask per mode bit; a mode bit i covers 2^i bytes.
  for (genvar gi = 0; gi <= OFF_W; gi++) begin : g_size
    assign w_size_mask_per[gi] = i_mode[gi] ? (2*BYTES)'((1 << (1 << gi)) - 1) : '0;
  end

  // Merge per-mode masks; illegal modes are flagged separately so the merge is don't-care there.
  always_comb begin
    w_size_mask = '0;
    for (int k = 0; k <= OFF_W; k++) begin
      w_size_mask = w_size_mask | w_size_mask_per[k];
    end
  end

  assign w_strb = w_size_mask << i_off;

  // Expand byte strobes to bit masks so lanes outside the store are forced to zero.
  for (genvar gi = 0; gi < 2*BYTES; gi++) begin : g_lane
    assign w_lane_mask[8*gi +: 8] = {8{w_strb[gi]}};
  end

  assign w_shifted = ({{DATA_W{1'b0}}, i_data} << {i_off, 3'b000}) & w_lane_mask;

  assign o_lo      = w_shifted[DATA_W-1:0];
  assign o_hi      = w_shifted[2*DATA_W-1:DATA_W];
  assign o_strb_lo = w_strb[BYTES-1:0];
  assign o_strb_hi = w_strb[2*BYTES-1:BYTES];
  assign o_split   = |w_strb[2*BYTES-1:BYTES];
  assign o_illegal = !$onehot(i_mode);
endmodule

// File: rtl/store_queue_unit.sv
// Store queue: DEPTH-entry FIFO of pre-decoded stores feeding the data SRAM,
// issuing boundary-crossing stores as two consecutive beats.
module store_queue_unit
  import store_queue_unit_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 4,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic         clk,
  input  logic         reset,
  store_queue_unit_if.slave sq
);
  localparam int BYTES = bytes_of(DATA_W);
  localparam int OFF_W = off_w_of(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - OFF_W;

  // Entry storage: word tag plus both decoded beats.
  logic [TAG_W-1:0]  r_tag_mem [DEPTH];
  logic [DATA_W-1:0] r_lo_mem  [DEPTH];
  logic [DATA_W-1:0] r_hi_mem  [DEPTH];
  logic [BYTES-1:0]  r_slo_mem [DEPTH];
  logic [BYTES-1:0]  r_shi_mem [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_err;
  sq_state_e         r_state;
  sq_state_e         w_state_next;

  logic [DATA_W-1:0] w_lo, w_hi;
  logic [BYTES-1:0]  w_slo, w_shi;
  logic              w_split, w_illegal;
  logic              w_full, w_push, w_drop, w_write, w_pop;
  logic [ADDR_W-1:0] w_base;
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [BYTES-1:0]  w_we;
  logic [DATA_W-1:0] w_wdata;

  store_queue_unit_align #(.DATA_W(DATA_W)) u_align (
    .i_off     (sq.st_addr[OFF_W-1:0]),
    .i_mode    (sq.st_mode),
    .i_data    (sq.st_wdata),
    .o_lo      (w_lo),
    .o_hi      (w_hi),
    .o_strb_lo (w_slo),
    .o_strb_hi (w_shi),
    .o_split   (w_split),
    .o_illegal (w_illegal)
  );

  assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign sq.st_ready = !reset && !w_full;
  assign w_push      = sq.st_valid && sq.st_ready;
  // A dropped store is still handshaken so the pipeline never stalls on it.
  assign w_drop      = w_illegal || (w_split && (ALLOW_MISALIGN == 0));
  assign w_write     = w_push && !w_drop;

  // Entry write; payload needs no reset since count gates its use.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_tag_mem[r_wr_ptr] <= sq.st_addr[ADDR_W-1:OFF_W];
      r_lo_mem[r_wr_ptr]  <= w_lo;
      r_hi_mem[r_wr_ptr]  <= w_hi;
      r_slo_mem[r_wr_ptr] <= w_slo;
      r_shi_mem[r_wr_ptr] <= w_shi;
    end
  end

  // Pointers, occupancy, drop pulse and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_state  <= S_ISSUE;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_write) - (PTR_W+1)'(w_pop);
      r_err   <= w_push && w_drop;
      r_state <= w_state_next;
    end
  end

  assign w_base = {r_tag_mem[r_rd_ptr], {OFF_W{1'b0}}};

  // Pop FSM: selects the beat presented to the SRAM and decides when the head retires.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_pop        = 1'b0;
    w_addr       = w_base;
    w_we         = '0;
    w_wdata      = '0;
    case (r_state)
      S_ISSUE: begin
        w_req = (r_count != '0);
        if (w_req) begin
          w_we    = r_slo_mem[r_rd_ptr];
          w_wdata = r_lo_mem[r_rd_ptr];
          if (sq.data_sram_addr_ok) begin
            if (|r_shi_mem[r_rd_ptr]) w_state_next = S_SPLIT;
            else                      w_pop        = 1'b1;
          end
        end
      end
      S_SPLIT: begin
        w_req   = 1'b1;
        w_addr  = w_base + ADDR_W'(BYTES);
        w_we    = r_shi_mem[r_rd_ptr];
        w_wdata = r_hi_mem[r_rd_ptr];
        if (sq.data_sram_addr_ok) begin
          w_pop        = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      default: w_state_next = S_ISSUE;
    endcase
  end

  assign sq.data_sram_req   = w_req;
  assign sq.data_sram_addr  = w_addr;
  assign sq.data_sram_we    = w_we;
  assign sq.data_sram_wdata = w_wdata;
  assign sq.store_err       = r_err;
  assign sq.sq_empty        = (r_count == '0) && (r_state == S_ISSUE);
endmodule

// File: tb/tb_store_queue_unit.sv
// Randomised scoreboard bench for store_queue_unit (32-bit data, depth 4),
// plus a second instance with misaligned stores disabled.
module tb_store_queue_unit;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    bit          last;
  } beat_t;

  logic clk;
  logic reset;

  store_queue_unit_if #(.DATA_W(32), .ADDR_W(32)) sif ();
  store_queue_unit_if #(.DATA_W(32), .ADDR_W(32)) nif ();

  store_queue_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .ALLOW_MISALIGN(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .sq    (sif)
  );

  store_queue_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .ALLOW_MISALIGN(0)) u_dut_nm (
    .clk   (clk),
    .reset (reset),
    .sq    (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  beat_t dir_q[$];
  int    dir_pending = 0;
  int    stores = 0;
  bit    exp_err = 0;
  int    beats_acc = 0;

  // captured handshake of the cycle that is ending
  bit          cap_push;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic [2:0]  cap_mode;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: place each byte of the store at its absolute address and group by word.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                                output bit err, output beat_t b0, output beat_t b1, output bit two);
    int size;
    logic [31:0] w0, ab;
    err = !(m == 3'b001 || m == 3'b010 || m == 3'b100);
    size = (m == 3'b001) ? 1 : (m == 3'b010) ? 2 : 4;
    w0 = a & ~32'h3;
    b0 = '{addr: w0, we: 4'h0, data: 32'h0, last: 1'b1};
    b1 = '{addr: w0 + 32'd4, we: 4'h0, data: 32'h0, last: 1'b1};
    two = 0;
    for (int j = 0; j < size; j++) begin
      ab = a + j;
      if ((ab & ~32'h3) == w0) begin
        b0.we[ab[1:0]] = 1'b1;
        b0.data[8*ab[1:0] +: 8] = d[8*j +: 8];
      end else begin
        b1.we[ab[1:0]] = 1'b1;
        b1.data[8*ab[1:0] +: 8] = d[8*j +: 8];
        two = 1;
      end
    end
    if (two) b0.last = 1'b0;
  endfunction

  // Capture accepted stores while inputs are stable.
  always @(negedge clk) begin
    cap_push = !reset && sif.st_valid && sif.st_ready;
    cap_addr = sif.st_addr;
    cap_data = sif.st_wdata;
    cap_mode = sif.st_mode;
  end

  // Stimulus side of the scoreboard: push expected beats at the accepting edge.
  always @(posedge clk) begin
    bit e, two;
    beat_t b0, b1, t;
    if (reset) begin
      exp_q.delete();
      stores  = 0;
      exp_err = 0;
    end else begin
      exp_err = 0;
      if (cap_push) begin
        model(cap_addr, cap_data, cap_mode, e, b0, b1, two);
        if (e) begin
          exp_err = 1;
        end else begin
          stores++;
          if (dir_pending > 0) begin
            dir_pending--;
            do begin
              t = dir_q.pop_front();
              exp_q.push_back(t);
            end while (!t.last && dir_q.size() > 0);
          end else begin
            exp_q.push_back(b0);
            if (two) exp_q.push_back(b1);
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      chk(sif.st_ready == 1'b0, "ready_in_reset", 64'(sif.st_ready), 64'd0);
    end else begin
      chk(sif.st_ready == (stores < 4), "st_ready", 64'(sif.st_ready), 64'(stores < 4));
      chk(sif.sq_empty == (exp_q.size() == 0), "sq_empty", 64'(sif.sq_empty), 64'(exp_q.size() == 0));
      chk(sif.store_err == exp_err, "store_err", 64'(sif.store_err), 64'(exp_err));
      chk(sif.data_sram_req == (exp_q.size() != 0), "req", 64'(sif.data_sram_req), 64'(exp_q.size() != 0));
      if (sif.data_sram_req && exp_q.size() != 0) begin
        b = exp_q[0];
        chk(sif.data_sram_addr == b.addr, "beat_addr", 64'(sif.data_sram_addr), 64'(b.addr));
        chk(sif.data_sram_we == b.we, "beat_we", 64'(sif.data_sram_we), 64'(b.we));
        chk(sif.data_sram_wdata == b.data, "beat_wdata", 64'(sif.data_sram_wdata), 64'(b.data));
        if (sif.data_sram_addr_ok) begin
          void'(exp_q.pop_front());
          if (b.last) stores--;
          beats_acc++;
          $display("beat addr=%08h we=%04b wdata=%08h last=%0d", b.addr, b.we, b.data, b.last);
        end
      end else if (!sif.data_sram_req) begin
        chk({sif.data_sram_we, sif.data_sram_wdata} == 36'h0, "idle_lanes",
            64'({sif.data_sram_we, sif.data_sram_wdata}), 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one store until accepted; returns cycles spent.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m, output int n);
    bit acc;
    acc = 0;
    n = 0;
    sif.st_valid = 1'b1;
    sif.st_addr  = a;
    sif.st_wdata = d;
    sif.st_mode  = m;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = sif.st_ready;
      cyc();
      n++;
    end
    sif.st_valid = 1'b0;
    if (!acc) chk(1'b0, "store_accept_timeout", 64'(n), 64'd200);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!(sif.sq_empty && exp_q.size() == 0) && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) chk(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Directed access on the instance without misaligned support.
  task automatic nm_try(input logic [31:0] a, input logic [2:0] m, input bit drop);
    nif.st_valid = 1'b1;
    nif.st_addr  = a;
    nif.st_wdata = 32'hCAFEF00D;
    nif.st_mode  = m;
    @(negedge clk);
    chk(nif.st_ready == 1'b1, "nm_ready", 64'(nif.st_ready), 64'd1);
    cyc();
    nif.st_valid = 1'b0;
    chk(nif.store_err == drop, "nm_err_pulse", 64'(nif.store_err), 64'(drop));
    chk(nif.data_sram_req == !drop, "nm_req", 64'(nif.data_sram_req), 64'(!drop));
    if (!drop) begin
      chk(nif.data_sram_addr == (a & ~32'h3), "nm_addr", 64'(nif.data_sram_addr), 64'(a & ~32'h3));
      chk(nif.data_sram_we == 4'hF, "nm_we", 64'(nif.data_sram_we), 64'hF);
    end
    cyc();
    chk(nif.store_err == 1'b0, "nm_err_once", 64'(nif.store_err), 64'd0);
    chk(nif.data_sram_req == 1'b0, "nm_no_req", 64'(nif.data_sram_req), 64'd0);
    chk(nif.sq_empty == 1'b1, "nm_empty", 64'(nif.sq_empty), 64'd1);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_1000 + $urandom_range(0, 63);
      1:       return 32'hFFFF_FFF8 + $urandom_range(0, 7);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] pick_mode();
    logic [2:0] bad [5];
    bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    if ($urandom_range(0, 99) < 10) return bad[$urandom_range(0, 4)];
    return 3'(1 << $urandom_range(0, 2));
  endfunction

  initial begin
    int n, b_start;
    reset = 1'b1;
    sif.st_valid = 1'b0; sif.st_addr = '0; sif.st_wdata = '0; sif.st_mode = '0;
    sif.data_sram_addr_ok = 1'b1;
    nif.st_valid = 1'b0; nif.st_addr = '0; nif.st_wdata = '0; nif.st_mode = '0;
    nif.data_sram_addr_ok = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk(nif.sq_empty == 1'b1, "nm_reset_empty", 64'(nif.sq_empty), 64'd1);

    // byte store into the top lane
    dir_q.push_back('{addr: 32'h1000, we: 4'b1000, data: 32'hAB000000, last: 1'b1});
    dir_pending = 1;
    do_store(32'h1003, 32'h000000AB, 3'b001, n);
    wait_empty();

    // half store across a word boundary: two back-to-back beats
    dir_q.push_back('{addr: 32'h1000, we: 4'b1000, data: 32'hEF000000, last: 1'b0});
    dir_q.push_back('{addr: 32'h1004, we: 4'b0001, data: 32'h000000BE, last: 1'b1});
    dir_pending = 1;
    do_store(32'h1003, 32'h0000BEEF, 3'b010, n);
    wait_empty();

    // fill with SRAM stalled, then release
    sif.data_sram_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h100 + 32'(4*i), 32'h11110000 + 32'(i), 3'b100, n);
      chk(n == 1, "fill_push", 64'(n), 64'd1);
    end
    sif.st_valid = 1'b1;
    sif.st_addr = 32'h200; sif.st_mode = 3'b100;
    repeat (3) cyc();
    sif.st_valid = 1'b0;
    sif.data_sram_addr_ok = 1'b1;
    wait_empty();

    // full-rate streaming with simultaneous push and pop at count 3
    sif.data_sram_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) do_store(32'h300 + 32'(4*i), $urandom, 3'b100, n);
    sif.data_sram_addr_ok = 1'b1;
    b_start = beats_acc;
    for (int i = 0; i < 10; i++) begin
      do_store(32'h400 + 32'(4*i), $urandom, 3'b100, n);
      chk(n == 1, "stream_push", 64'(n), 64'd1);
    end
    chk(beats_acc - b_start == 10, "stream_rate", 64'(beats_acc - b_start), 64'd10);
    wait_empty();

    // reset while the second beat is stalled
    do_store(32'h1003, 32'h0000BEEF, 3'b010, n);
    cyc();
    sif.data_sram_addr_ok = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sif.data_sram_addr_ok = 1'b1;
    repeat (4) cyc();

    // instance without misaligned support
    nm_try(32'h2002, 3'b100, 1'b1);
    nm_try(32'h2000, 3'b011, 1'b1);
    nm_try(32'h3000, 3'b100, 1'b0);

    // randomised traffic
    for (int c = 0; c < 800; c++) begin
      sif.st_valid = ($urandom_range(0, 99) < 55);
      sif.st_addr  = pick_addr();
      sif.st_wdata = $urandom;
      sif.st_mode  = pick_mode();
      sif.data_sram_addr_ok = ($urandom_range(0, 99) < 75);
      cyc();
    end
    sif.st_valid = 1'b0;
    sif.data_sram_addr_ok = 1'b1;
    wait_empty();
    chk(exp_q.size() == 0, "final_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
